// File: rtl/mem1_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around the mem1 register-file memory.
// It owns the pointers and occupancy and presents mem1's registered Q as the FIFO head.
module mem1_fifo_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SIZE_E = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WIDTH-1:0]  IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  OUT_DATA,
  output logic [SIZE_E:0]   LEVEL,
  output logic              MEM_WRITE,
  output logic              MEM_READ,
  output logic [SIZE_E-1:0] MEM_WRADDR,
  output logic [SIZE_E-1:0] MEM_RDADDR,
  output logic [WIDTH-1:0]  MEM_D,
  input  logic [WIDTH-1:0]  MEM_Q
);

  localparam logic [SIZE_E:0]   DEPTH_C = (SIZE_E+1)'(2**SIZE_E);
  localparam logic [SIZE_E-1:0] PTR_ONE = SIZE_E'(1);

  logic [SIZE_E-1:0] wr_ptr;
  logic [SIZE_E-1:0] rd_ptr;
  logic [SIZE_E:0]   count;
  logic              out_valid;
  logic              mem_read;
  logic              push;
  logic              pop;

  // mem_read doubles as "out of reset for at least one edge", which gates IN_READY.
  assign IN_READY   = mem_read & (count != DEPTH_C) & ~FLUSH;
  assign push       = IN_VALID & IN_READY;
  assign pop        = out_valid & OUT_READY & ~FLUSH;

  assign MEM_WRITE  = push;
  assign MEM_WRADDR = wr_ptr;
  assign MEM_D      = IN_DATA;
  assign MEM_READ   = mem_read;
  // Look ahead on pop so mem1 latches the next head on the same edge.
  assign MEM_RDADDR = pop ? rd_ptr + PTR_ONE : rd_ptr;

  assign OUT_VALID  = out_valid;
  assign OUT_DATA   = MEM_Q;
  assign LEVEL      = count;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      mem_read <= 1'b1;
      if (FLUSH) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        count <= count + (SIZE_E+1)'(push) - (SIZE_E+1)'(pop);
        // A word written this edge is not yet readable: mem1 returns old data on collision.
        out_valid <= (count - (SIZE_E+1)'(pop)) != '0;
      end
    end
  end

endmodule

// File: tb/tb_mem1_fifo_ctrl.sv
// Bench for mem1_fifo_ctrl: behavioural mem1 plus a queue-based FIFO reference model.
module tb_mem1_fifo_ctrl;

  localparam int WIDTH  = 8;
  localparam int SIZE_E = 6;
  localparam int DEPTH  = 64;

  logic              CLK = 1'b0;
  logic              RSTN;
  logic              FLUSH;
  logic              IN_VALID;
  logic              IN_READY;
  logic [WIDTH-1:0]  IN_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [WIDTH-1:0]  OUT_DATA;
  logic [SIZE_E:0]   LEVEL;
  logic              MEM_WRITE;
  logic              MEM_READ;
  logic [SIZE_E-1:0] MEM_WRADDR;
  logic [SIZE_E-1:0] MEM_RDADDR;
  logic [WIDTH-1:0]  MEM_D;
  logic [WIDTH-1:0]  MEM_Q;

  mem1_fifo_ctrl #(.WIDTH(WIDTH), .SIZE_E(SIZE_E)) dut (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .LEVEL(LEVEL), .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
    .MEM_WRADDR(MEM_WRADDR), .MEM_RDADDR(MEM_RDADDR),
    .MEM_D(MEM_D), .MEM_Q(MEM_Q)
  );

  always #5 CLK = ~CLK;

  // mem1: registered read, old data returned on same-edge read/write collision.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (MEM_WRITE) mem[MEM_WRADDR] <= MEM_D;
    if (MEM_READ)  MEM_Q <= mem[MEM_RDADDR];
  end

  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  bit   alive = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: drive, check against model, then advance model on the edge.
  task automatic step(input logic fl, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    bit exp_rdy, exp_vld, push, pop;
    ent_t e;
    FLUSH = fl; IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
    #1;
    if (!RSTN) begin
      q.delete();
      alive = 0;
    end
    exp_rdy = RSTN && alive && (q.size() != DEPTH) && !fl;
    // The head is presentable only if it was stored before the most recent edge.
    exp_vld = (q.size() > 0) && (q[0].t < cyc - 1);
    chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
    chk("out_valid", 32'(OUT_VALID), 32'(exp_vld));
    chk("level", 32'(LEVEL), 32'(q.size()));
    chk("mem_read", 32'(MEM_READ), 32'(alive));
    chk("mem_write", 32'(MEM_WRITE), 32'(exp_rdy && iv));
    if (exp_vld) chk("out_data", 32'(OUT_DATA), 32'(q[0].d));
    push = exp_rdy && iv;
    pop  = exp_vld && ordy && !fl;
    @(posedge CLK);
    if (!RSTN) begin
      q.delete();
      alive = 0;
    end else begin
      alive = 1;
      if (fl) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          e.d = d; e.t = cyc;
          q.push_back(e);
        end
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, WIDTH'($urandom), 1'b1);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, WIDTH'(base + i), 1'b0);
  endtask

  initial begin
    int pv, pr;
    RSTN = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h11, 1'b1);
    RSTN = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ready_after_rst", 32'(IN_READY), 32'd1);

    // Single word
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("single_data", 32'(OUT_DATA), 32'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("single_empty", 32'(OUT_VALID), 32'd0);

    // Streaming 200 words with the consumer always ready
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, WIDTH'(i), 1'b1);
      if (i >= 1) begin
        chk("stream_valid", 32'(OUT_VALID), 32'd1);
        chk("stream_lvl_le2", 32'(LEVEL <= 2), 32'd1);
      end
    end
    drain(4);

    // Fill, overfill attempt, drain; twice to exercise wrap
    for (int r = 0; r < 2; r++) begin
      fill(DEPTH, r * 100);
      chk("full_level", 32'(LEVEL), 32'(DEPTH));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 1'b0);
      drain(DEPTH + 3);
    end

    // Backpressure mid-stream
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, WIDTH'(8'h40 + i), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, WIDTH'(8'h50 + i), 1'b0);
    drain(16);

    // Flush with a concurrent push
    fill(10, 8'h70);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("flush_level", 32'(LEVEL), 32'd0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    drain(3);

    // Asynchronous reset pulse mid-stream
    fill(10, 8'h20);
    RSTN = 1'b0;
    step(1'b0, 1'b1, 8'hDD, 1'b1);
    RSTN = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    drain(3);

    // Randomised traffic with shifting push/pop rates and rare flushes
    for (int blk = 0; blk < 15; blk++) begin
      pv = $urandom_range(10, 100);
      pr = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pv,
             WIDTH'($urandom), $urandom_range(0, 99) < pr);
    end
    drain(DEPTH + 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
